// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: shared ALU control codes, RV32I opcodes and operand-select types
// Contents: ALU_* control codes, OPC_* opcodes, XLEN_DEF, d1/d2 operand-select enums.
package alu_issue_stage_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    typedef enum logic [1:0] {D1_ZERO, D1_RS1, D1_PC} d1_sel_t;
    typedef enum logic [1:0] {D2_ZERO, D2_RS2, D2_IMM} d2_sel_t;
endpackage

// File: rtl/alu_issue_stage_alu_ctrl_decode.sv
// alu_ctrl_decode: combinational RV32I opcode/funct decode into ALU control and operand selects
// Ports: opcode, funct3, funct7b5 in; alu_control, d1_sel, d2_sel, reg_write_en, illegal out.
module alu_ctrl_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control,
    output d1_sel_t    d1_sel,
    output d2_sel_t    d2_sel,
    output logic       reg_write_en,
    output logic       illegal
);
    logic is_op, is_opi, is_lui, is_auipc, is_mem, legal;
    always_comb begin
        is_op = opcode == OPC_OP;
        is_opi = opcode == OPC_OP_IMM;
        is_lui = opcode == OPC_LUI;
        is_auipc = opcode == OPC_AUIPC;
        is_mem = opcode == OPC_LOAD || opcode == OPC_STORE;
        legal = is_op | is_opi | is_lui | is_auipc | is_mem;
        // bit 30 selects SUB/SRA for OP, but only SRA for OP-IMM where it is immediate data otherwise
        alu_control = is_op  ? {funct7b5 & (funct3 == 3'b000 || funct3 == 3'b101), funct3} :
                      is_opi ? {funct7b5 & (funct3 == 3'b101), funct3} : ALU_ADD;
        d1_sel = (is_op | is_opi | is_mem) ? D1_RS1 : is_auipc ? D1_PC : D1_ZERO;
        d2_sel = is_op ? D2_RS2 : (is_opi | is_lui | is_auipc | is_mem) ? D2_IMM : D2_ZERO;
        reg_write_en = legal & (opcode != OPC_STORE);
        illegal = !legal;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-execute register producing ALU operands and control behind valid/ready
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready + opcode, funct3, funct7b5, rd_in,
//        rs1_data, rs2_data, imm, pc_in from decode; out_valid/out_ready + alu_d1, alu_d2,
//        alu_control, rd_out, reg_write, illegal, pc_out to execute.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic [RA_W-1:0] rd_in,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_d1,
    output logic [XLEN-1:0] alu_d2,
    output logic [3:0]      alu_control,
    output logic [RA_W-1:0] rd_out,
    output logic            reg_write,
    output logic            illegal,
    output logic [XLEN-1:0] pc_out
);
    logic [3:0] ctrl;
    d1_sel_t d1_sel;
    d2_sel_t d2_sel;
    logic rw_en, ill, load;
    logic [XLEN-1:0] d1, d2;
    alu_ctrl_decode u_dec (
        .opcode(opcode),
        .funct3(funct3),
        .funct7b5(funct7b5),
        .alu_control(ctrl),
        .d1_sel(d1_sel),
        .d2_sel(d2_sel),
        .reg_write_en(rw_en),
        .illegal(ill)
    );
    always_comb begin
        in_ready = !out_valid | out_ready | flush;
        // a beat offered during flush is taken off the bus but never stored
        load = in_valid & in_ready & !flush;
        d1 = d1_sel == D1_RS1 ? rs1_data : d1_sel == D1_PC ? pc_in : '0;
        d2 = d2_sel == D2_RS2 ? rs2_data : d2_sel == D2_IMM ? imm : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_d1 <= '0;
            alu_d2 <= '0;
            alu_control <= ALU_ADD;
            rd_out <= '0;
            reg_write <= 1'b0;
            illegal <= 1'b0;
            pc_out <= '0;
        end else begin
            out_valid <= flush ? 1'b0 : load ? 1'b1 : out_ready ? 1'b0 : out_valid;
            if (load) begin
                alu_d1 <= d1;
                alu_d2 <= d2;
                alu_control <= ctrl;
                rd_out <= rd_in;
                reg_write <= rw_en & (rd_in != '0);
                illegal <= ill;
                pc_out <= pc_in;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage covering decode, handshake, flush and reset
module tb_alu_issue_stage;
    logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0, funct7b5 = 0;
    logic in_ready, out_valid, reg_write, illegal;
    logic [6:0] opcode = 0;
    logic [2:0] funct3 = 0;
    logic [4:0] rd_in = 0, rd_out;
    logic [31:0] rs1_data = 0, rs2_data = 0, imm = 0, pc_in = 0;
    logic [31:0] alu_d1, alu_d2, pc_out;
    logic [3:0] alu_control;
    int checks = 0, failures = 0;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
        logic [31:0] pc;
    } exp_t;
    exp_t q[$];
    exp_t e_m, g_m;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .rd_in(rd_in),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready), .alu_d1(alu_d1), .alu_d2(alu_d2),
        .alu_control(alu_control), .rd_out(rd_out), .reg_write(reg_write),
        .illegal(illegal), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic b,
                                   input logic [4:0] rd, input logic [31:0] r1, r2, im, pc);
        exp_t e;
        e = '0;
        e.rd = rd;
        e.pc = pc;
        e.rw = rd != 0;
        case (op)
            7'h33: begin
                e.d1 = r1; e.d2 = r2;
                e.ctrl = f3 == 0 ? (b ? 4'h8 : 4'h0) : f3 == 5 ? (b ? 4'hd : 4'h5) : {1'b0, f3};
            end
            7'h13: begin e.d1 = r1; e.d2 = im; e.ctrl = (f3 == 5 && b) ? 4'hd : {1'b0, f3}; end
            7'h37: e.d2 = im;
            7'h17: begin e.d1 = pc; e.d2 = im; end
            7'h03: begin e.d1 = r1; e.d2 = im; end
            7'h23: begin e.d1 = r1; e.d2 = im; e.rw = 0; end
            default: begin e.rw = 0; e.ill = 1; end
        endcase
        return e;
    endfunction

    // scoreboard: pop on every output transfer, push on every accepted (non-flushed) input
    always @(negedge clk) begin
        if (rst || flush) q.delete();
        else begin
            if (out_valid && out_ready) begin
                checks++;
                g_m = {alu_d1, alu_d2, alu_control, rd_out, reg_write, illegal, pc_out};
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got=%h required=none", g_m);
                end else begin
                    e_m = q.pop_front();
                    if (g_m !== e_m) begin
                        failures++;
                        $display("FAIL sb_beat got=%h required=%h", g_m, e_m);
                    end
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(opcode, funct3, funct7b5, rd_in, rs1_data, rs2_data, imm, pc_in));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic b,
                          input logic [4:0] rd, input logic [31:0] r1, r2, im, pc);
        opcode = op; funct3 = f3; funct7b5 = b; rd_in = rd;
        rs1_data = r1; rs2_data = r2; imm = im; pc_in = pc;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        checks++;
        if ({out_valid, alu_d1, alu_d2, alu_control, rd_out, reg_write, illegal, pc_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d1=%h d2=%h c=%h", out_valid, alu_d1, alu_d2, alu_control);
        end
        rst = 0;
        #1;
        checks++;
        if (in_ready !== 1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    endtask

    task automatic test_op_sub();
        out_ready = 1;
        set_in(7'h33, 3'b000, 1, 5, 7, 3, 32'h55, 32'h100);
        in_valid = 1;
        tick();
        in_valid = 0;
        checks++;
        if ({out_valid, alu_control, alu_d1, alu_d2, reg_write} !== {1'b1, 4'b1000, 32'd7, 32'd3, 1'b1}) begin
            failures++;
            $display("FAIL op_sub got v=%b c=%b d1=%h d2=%h rw=%b required v=1 c=1000 d1=7 d2=3 rw=1",
                     out_valid, alu_control, alu_d1, alu_d2, reg_write);
        end
        tick();
    endtask

    task automatic test_op_imm();
        out_ready = 1;
        set_in(7'h13, 3'b101, 1, 2, 32'h80000000, 32'h9, 32'h403, 0);
        in_valid = 1;
        tick();
        checks++;
        if (alu_control !== 4'b1101) begin failures++; $display("FAIL srai_ctrl got=%b required=1101", alu_control); end
        set_in(7'h13, 3'b000, 1, 2, 32'h10, 32'h9, 32'hfffffc00, 0);
        tick();
        in_valid = 0;
        checks++;
        if (alu_control !== 4'b0000 || alu_d2 !== 32'hfffffc00) begin
            failures++;
            $display("FAIL addi_b30 got c=%b d2=%h required c=0000 d2=fffffc00", alu_control, alu_d2);
        end
        tick();
    endtask

    task automatic test_auipc_rd0();
        out_ready = 1;
        set_in(7'h17, 3'b000, 0, 9, 32'h77, 32'h66, 32'h2000, 32'h1000);
        in_valid = 1;
        tick();
        checks++;
        if ({alu_d1, alu_d2, alu_control} !== {32'h1000, 32'h2000, 4'b0000}) begin
            failures++;
            $display("FAIL auipc got d1=%h d2=%h c=%b required d1=1000 d2=2000 c=0000", alu_d1, alu_d2, alu_control);
        end
        set_in(7'h33, 3'b110, 0, 0, 32'h1, 32'h2, 0, 0);
        tick();
        in_valid = 0;
        checks++;
        if (reg_write !== 0 || alu_control !== 4'b0110) begin
            failures++;
            $display("FAIL rd0_op got rw=%b c=%b required rw=0 c=0110", reg_write, alu_control);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 0;
        set_in(7'h03, 3'b010, 0, 4, 32'haaaa0000, 0, 32'h10, 32'h200);
        in_valid = 1;
        tick();
        set_in(7'h23, 3'b010, 0, 6, 32'hbbbb0000, 32'h1, 32'h20, 32'h204);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, in_ready, alu_d1, alu_d2, rd_out, reg_write, pc_out} !==
                {1'b1, 1'b0, 32'haaaa0000, 32'h10, 5'd4, 1'b1, 32'h200}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got v=%b ir=%b d1=%h d2=%h rd=%0d rw=%b pc=%h", i,
                         out_valid, in_ready, alu_d1, alu_d2, rd_out, reg_write, pc_out);
            end
            tick();
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1) begin failures++; $display("FAIL release_in_ready got=%b required=1", in_ready); end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1 || alu_d1 !== 32'hbbbb0000 || reg_write !== 0) begin
            failures++;
            $display("FAIL b2b_reload got v=%b d1=%h rw=%b required v=1 d1=bbbb0000 rw=0", out_valid, alu_d1, reg_write);
        end
        tick();
        tick();
    endtask

    task automatic test_flush();
        out_ready = 0;
        set_in(7'h33, 3'b100, 0, 8, 32'h1, 32'h2, 0, 32'h300);
        in_valid = 1;
        tick();
        set_in(7'h33, 3'b111, 0, 9, 32'h3, 32'h4, 0, 32'h304);
        flush = 1;
        #1;
        checks++;
        if (in_ready !== 1) begin failures++; $display("FAIL flush_in_ready got=%b required=1", in_ready); end
        tick();
        flush = 0;
        in_valid = 0;
        out_ready = 1;
        checks++;
        if (out_valid !== 0) begin failures++; $display("FAIL flush_clear got=%b required=0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 0) begin failures++; $display("FAIL flush_no_emit got=%b required=0", out_valid); end
    endtask

    task automatic test_illegal_and_reset();
        out_ready = 0;
        set_in(7'h7f, 3'b001, 1, 3, 32'h11, 32'h22, 32'h33, 32'h400);
        in_valid = 1;
        tick();
        in_valid = 0;
        checks++;
        if ({illegal, reg_write, alu_control, alu_d1, alu_d2} !== {1'b1, 1'b0, 4'b0000, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL illegal got ill=%b rw=%b c=%b d1=%h d2=%h required ill=1 rw=0 c=0000 d1=0 d2=0",
                     illegal, reg_write, alu_control, alu_d1, alu_d2);
        end
        tick();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({out_valid, alu_d1, alu_d2, alu_control, rd_out, reg_write, illegal, pc_out} !== '0) begin
            failures++;
            $display("FAIL reset_mid_stall got v=%b ill=%b pc=%h rd=%0d", out_valid, illegal, pc_out, rd_out);
        end
        out_ready = 1;
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops[7];
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h7f};
        for (int i = 0; i < 80; i++) begin
            set_in(ops[$urandom_range(0, 6)], 3'($urandom), 1'($urandom), 5'($urandom),
                   $urandom, $urandom, $urandom, $urandom);
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        tick();
        tick();
        checks++;
        if (q.size() != 0 || out_valid !== 0) begin
            failures++;
            $display("FAIL drain got pending=%0d v=%b required pending=0 v=0", q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_op_sub();
        test_op_imm();
        test_auipc_rd0();
        test_back_to_back();
        test_flush();
        test_illegal_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
